// File: rtl/serializer.sv
// Parallel-to-serial transmitter: valid/ready word intake into a one-word holding buffer,
// MSB-first shift-out on each enabled clock, with a frame-active flag and end-of-word pulse.
module serializer #(
    parameter int unsigned DATA_SIZE = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iValid,
    input  logic [DATA_SIZE-1:0] iData,
    output logic                 oReady,
    output logic                 oData_out,
    output logic                 oLoading,
    output logic                 oDone_flag,
    output logic                 oBusy
);

    localparam int unsigned CntW = $clog2(DATA_SIZE);

    typedef enum logic {StIdle, StShift} state_e;

    state_e               r_state;
    logic [DATA_SIZE-1:0] r_hold;
    logic                 r_hold_valid;
    logic [DATA_SIZE-1:0] r_shift;
    logic [CntW-1:0]      r_bit_cnt;
    logic                 r_data_out;
    logic                 r_loading;
    logic                 r_done;

    logic w_accept;
    logic w_last;
    logic w_load;

    assign oReady   = !r_hold_valid && !iRst;
    assign w_accept = iValid && oReady;
    // Last bit has now been presented for a full enabled period.
    assign w_last   = (r_state == StShift) && (r_bit_cnt == '0);
    assign w_load   = iEn && r_hold_valid && ((r_state == StIdle) || w_last);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state      <= StIdle;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_data_out   <= 1'b0;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Accept and drain are mutually exclusive: accept needs an empty buffer.
            if (w_accept) begin
                r_hold       <= iData;
                r_hold_valid <= 1'b1;
            end

            if (w_load) begin
                r_state      <= StShift;
                r_shift      <= r_hold;
                r_data_out   <= r_hold[DATA_SIZE-1];
                r_loading    <= 1'b1;
                r_bit_cnt    <= CntW'(DATA_SIZE - 1);
                r_hold_valid <= 1'b0;
            end

            if (iEn && (r_state == StShift)) begin
                if (w_last) begin
                    r_done <= 1'b1;
                    if (!r_hold_valid) begin
                        r_state    <= StIdle;
                        r_loading  <= 1'b0;
                        r_data_out <= 1'b0;
                    end
                end else begin
                    r_shift    <= r_shift << 1;
                    r_data_out <= r_shift[DATA_SIZE-2];
                    r_bit_cnt  <= r_bit_cnt - CntW'(1);
                end
            end
        end
    end

    assign oData_out  = r_data_out;
    assign oLoading   = r_loading;
    assign oDone_flag = r_done;
    assign oBusy      = (r_state == StShift) || r_hold_valid;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed and random stimulus compared cycle by cycle against a
// word/bit-position model, plus an end-to-end check of the serial stream against accepted words.
module tb_serializer;

    localparam int unsigned DS = 4;

    logic          iClk;
    logic          iRst;
    logic          iEn;
    logic          iValid;
    logic [DS-1:0] iData;
    logic          oReady;
    logic          oData_out;
    logic          oLoading;
    logic          oDone_flag;
    logic          oBusy;

    serializer #(.DATA_SIZE(DS)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iEn       (iEn),
        .iValid    (iValid),
        .iData     (iData),
        .oReady    (oReady),
        .oData_out (oData_out),
        .oLoading  (oLoading),
        .oDone_flag(oDone_flag),
        .oBusy     (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending word, the word on the wire and which bit of it is showing.
    bit          m_hold_valid = 0;
    logic [DS-1:0] m_hold     = '0;
    bit          m_active     = 0;
    logic [DS-1:0] m_word     = '0;
    int          m_pos        = 0;
    bit          m_done       = 0;
    bit          m_acc        = 0;

    bit got_q[$];
    bit exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_bit();
        return m_active ? m_word[DS-1-m_pos] : 1'b0;
    endfunction

    task automatic step(input bit rst, input bit en, input bit valid, input logic [DS-1:0] data);
        iRst   = rst;
        iEn    = en;
        iValid = valid;
        iData  = data;
        #1;
        chk("ready", {31'd0, oReady}, {31'd0, (!m_hold_valid && !rst)});
        m_acc = valid && !m_hold_valid && !rst;
        if (!rst && en && oLoading) got_q.push_back(oData_out);
        @(posedge iClk);
        if (rst) begin
            m_hold_valid = 0;
            m_active     = 0;
            m_pos        = 0;
            m_done       = 0;
            got_q.delete();
            exp_q.delete();
        end else begin
            m_done = 0;
            if (en) begin
                if (m_active && m_pos == DS - 1) begin
                    m_done = 1;
                    if (m_hold_valid) begin
                        m_word       = m_hold;
                        m_pos        = 0;
                        m_hold_valid = 0;
                    end else begin
                        m_active = 0;
                    end
                end else if (m_active) begin
                    m_pos++;
                end else if (m_hold_valid) begin
                    m_active     = 1;
                    m_word       = m_hold;
                    m_pos        = 0;
                    m_hold_valid = 0;
                end
            end
            if (m_acc) begin
                m_hold       = data;
                m_hold_valid = 1;
                for (int i = DS - 1; i >= 0; i--) exp_q.push_back(data[i]);
            end
        end
        #1;
        chk("data_out", {31'd0, oData_out},  {31'd0, m_bit()});
        chk("loading",  {31'd0, oLoading},   {31'd0, m_active});
        chk("done",     {31'd0, oDone_flag}, {31'd0, m_done});
        chk("busy",     {31'd0, oBusy},      {31'd0, (m_active || m_hold_valid)});
    endtask

    task automatic check_stream();
        chk("stream_len", got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < got_q.size(); i++) begin
                chk("stream_bit", {31'd0, got_q[i]}, {31'd0, exp_q[i]});
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst = 1'b1; iEn = 1'b0; iValid = 1'b0; iData = '0;

        // Reset held two clocks with a word offered: nothing captured.
        step(1, 1, 1, 4'hF);
        step(1, 1, 1, 4'hF);
        step(0, 0, 0, 4'h0);

        // Single word 1011 with enable tied high.
        step(0, 1, 1, 4'b1011);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 4'h0);
        check_stream();

        // Alternating enable: each bit held two clocks.
        step(0, 0, 1, 4'b1100);
        for (int i = 0; i < 12; i++) step(0, (i % 2) == 0, 0, 4'h0);
        check_stream();

        // Back-to-back words with valid held high.
        step(0, 1, 1, 4'hA);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 4'h5);
            if (m_acc) break;
        end
        for (int i = 0; i < 10; i++) step(0, 1, 0, 4'h0);
        check_stream();

        // Backpressure: buffer full, iData churning, enable low then high.
        step(0, 0, 1, 4'h3);
        for (int i = 0; i < 4; i++) step(0, 0, 1, DS'($urandom));
        step(0, 1, 1, DS'($urandom));
        step(0, 1, 1, 4'hE);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 4'h0);
        check_stream();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, DS'($urandom));
        end
        for (int i = 0; i < 30; i++) step(0, 1, 0, 4'h0);
        check_stream();

        // Reset after two bits of 0110 with another word held.
        step(0, 1, 1, 4'b0110);
        step(0, 1, 1, 4'b1001);
        step(0, 1, 1, 4'b1001);
        step(1, 0, 0, 4'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'h0);
        check_stream();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter for the XOR cipher serial link. It accepts DATA_SIZE-bit words through a valid/ready handshake and shifts each word out MSB first, one bit per enabled clock. It drives a frame-active flag alongside the bit stream, so the receiving deserializer can use it directly as its loading input. A one-word holding buffer lets consecutive words go out back-to-back with no idle bit between them.

## Interface
- DATA_SIZE, 4, word width in bits; legal range ≥ 2
- iClk  in  1  system clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-high
- iEn  in  1  bit-rate strobe; the shifter/FSM advances only on edges where iEn=1
- iValid  in  1  upstream word valid
- iData  in  DATA_SIZE  upstream parallel word
- oReady  out  1  holding buffer can accept a word; equals !hold_valid && !iRst
- oData_out  out  1  serial bit, MSB first, registered
- oLoading  out  1  high while oData_out carries a valid frame bit, registered
- oDone_flag  out  1  one-clock pulse after the last bit of a word, registered
- oBusy  out  1  state==SHIFT or holding buffer full

## Operation
- State: hold_q[DATA_SIZE], hold_valid, shift_q[DATA_SIZE], bit_cnt (clog2(DATA_SIZE) bits, counts bits remaining after the current one), FSM {IDLE, SHIFT}.
- Reset (iRst=1 at an edge): FSM→IDLE; hold_valid=0; shift_q=0; bit_cnt=0; oData_out=0; oLoading=0; oDone_flag=0. oReady=0 while iRst=1; iValid is ignored.
- Accept: if iValid && oReady at an edge, then hold_q←iData and hold_valid←1. Acceptance is independent of iEn.
- Every edge: oDone_flag defaults to 0.
- IDLE, iEn=1, hold_valid=1: load the word.
  - shift_q←hold_q; oData_out←hold_q[MSB]; oLoading←1; bit_cnt←DATA_SIZE-1; hold_valid←0.
  - Go to SHIFT.
- SHIFT, iEn=1, bit_cnt≠0: shift_q shifts left by one; oData_out←next bit; bit_cnt−1.
- SHIFT, iEn=1, bit_cnt=0 (last bit was presented for a full enabled period):
  - oDone_flag←1.
  - If hold_valid=1: load the next word as in IDLE. Stay in SHIFT; oLoading stays 1.
  - Otherwise: FSM→IDLE; oLoading←0; oData_out←0.
- iEn=0: FSM, shift_q, bit_cnt and the outputs hold their values. oDone_flag still clears after its one clock.
- The holding buffer is never written and drained on the same edge: oReady=0 whenever hold_valid=1.
- Reset mid-frame aborts the word. No oDone_flag pulse is produced, and the held word is discarded.

## Timing
- Word accepted at edge k: the first bit appears on oData_out after the first edge with iEn=1 strictly after k.
- Each bit is held from one enabled edge to the next. With iEn tied high, that is exactly 1 clock per bit.
- A word occupies DATA_SIZE enabled periods. oDone_flag is high for exactly 1 clock, in the clock following the enabled edge that ends the word.
- Back-to-back: if the holding buffer is full when a word ends, the MSB of the next word follows the previous LSB with no gap, and oLoading never drops.
- oReady returns to 1 in the clock after the buffer is drained into shift_q.
- The word in shift_q is unaffected by changes on iData and by new acceptances.

## Test plan
- Reset: assert iRst 2 clocks with iValid=1 → oData_out=oLoading=oDone_flag=oBusy=0 and oReady=0 during reset, nothing captured; oReady=1 the clock after release.
- Single word, DATA_SIZE=4, iEn=1 always, iData=4'b1011 accepted at edge 0 → oData_out=1,0,1,1 on clocks 1–4; oLoading=1 on clocks 1–4 only; oDone_flag=1 on clock 5 only.
- iEn toggling 1,0,1,0…, iData=4'b1100 → each bit held 2 clocks; oLoading high for 8 clocks; one oDone_flag pulse.
- Back-to-back: 4'hA then 4'h5 with iValid held high, iEn=1 → 8 consecutive bits 1,0,1,0,0,1,0,1; oLoading continuously high; oDone_flag pulses after bit 4 and after bit 8; the second word is accepted while the first is shifting.
- Backpressure: hold full, iValid=1, iData changing every clock → oReady=0; iData is ignored; the transmitted words are exactly the two accepted ones.
- Reset after 2 bits of 4'b0110 with a word held → next clock all outputs 0 and oReady=1; no oDone_flag; no remaining bits transmitted.
